// File: rtl/demux16_1to4_buf.sv
// rtl/demux16_1to4_buf.sv - 1-to-4 buffered stream distributor with per-channel delivery counters
module demux16_1to4_buf #(
    parameter int DW    = 16,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       SEL,
    input  logic [DW-1:0]    D_IN,
    output logic [3:0]       OUT_VALID,
    input  logic [3:0]       OUT_READY,
    output logic [DW-1:0]    D_OUT0,
    output logic [DW-1:0]    D_OUT1,
    output logic [DW-1:0]    D_OUT2,
    output logic [DW-1:0]    D_OUT3,
    input  logic             CLR_CNT,
    output logic [CNT_W-1:0] CNT0,
    output logic [CNT_W-1:0] CNT1,
    output logic [CNT_W-1:0] CNT2,
    output logic [CNT_W-1:0] CNT3
);

    // One holding register per channel; valid_q[n] is the FULL flag of channel n.
    logic [3:0]       valid_q;
    logic [3:0]       valid_d;
    logic [DW-1:0]    data_q [4];
    logic [DW-1:0]    data_d [4];
    logic [CNT_W-1:0] cnt_q  [4];
    logic [CNT_W-1:0] cnt_d  [4];

    logic       acc;
    logic [3:0] dlv;

    // A full channel can still take a word if its consumer drains it this cycle,
    // so ready is combinational from OUT_READY and never looks at IN_VALID.
    assign IN_READY = ~valid_q[SEL] | OUT_READY[SEL];
    assign acc      = IN_VALID & IN_READY;
    assign dlv      = valid_q & OUT_READY;

    // Channel fill/drain: a write to the addressed channel wins over its own drain.
    always_comb begin
        valid_d = valid_q;
        for (int n = 0; n < 4; n++) begin
            data_d[n] = data_q[n];
            if (acc && (SEL == 2'(n))) begin
                valid_d[n] = 1'b1;
                data_d[n]  = D_IN;
            end else if (dlv[n]) begin
                valid_d[n] = 1'b0;
            end
        end
    end

    // Delivery counters: clear has priority over a same-cycle delivery; wrap is natural.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            cnt_d[n] = cnt_q[n];
            if (CLR_CNT) begin
                cnt_d[n] = '0;
            end else if (dlv[n]) begin
                cnt_d[n] = cnt_q[n] + CNT_W'(1);
            end
        end
    end

    // State registers; reset discards any buffered words immediately.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q <= '0;
            for (int n = 0; n < 4; n++) begin
                data_q[n] <= '0;
                cnt_q[n]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int n = 0; n < 4; n++) begin
                data_q[n] <= data_d[n];
                cnt_q[n]  <= cnt_d[n];
            end
        end
    end

    assign OUT_VALID = valid_q;
    assign D_OUT0    = data_q[0];
    assign D_OUT1    = data_q[1];
    assign D_OUT2    = data_q[2];
    assign D_OUT3    = data_q[3];
    assign CNT0      = cnt_q[0];
    assign CNT1      = cnt_q[1];
    assign CNT2      = cnt_q[2];
    assign CNT3      = cnt_q[3];

endmodule

// File: tb/tb_demux16_1to4_buf.sv
// tb/tb_demux16_1to4_buf.sv - directed self-checking bench for demux16_1to4_buf
module tb_demux16_1to4_buf;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [1:0]  SEL;
    logic [15:0] D_IN;
    logic [3:0]  OUT_VALID;
    logic [3:0]  OUT_READY;
    logic [15:0] D_OUT0, D_OUT1, D_OUT2, D_OUT3;
    logic        CLR_CNT;
    logic [7:0]  CNT0, CNT1, CNT2, CNT3;

    int tests_run = 0;
    int tests_failed = 0;

    demux16_1to4_buf #(.DW(16), .CNT_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .SEL(SEL), .D_IN(D_IN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .D_OUT0(D_OUT0), .D_OUT1(D_OUT1), .D_OUT2(D_OUT2), .D_OUT3(D_OUT3),
        .CLR_CNT(CLR_CNT),
        .CNT0(CNT0), .CNT1(CNT1), .CNT2(CNT2), .CNT3(CNT3)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] dout(input int i);
        case (i)
            0: return D_OUT0;
            1: return D_OUT1;
            2: return D_OUT2;
            default: return D_OUT3;
        endcase
    endfunction

    function automatic logic [7:0] cnt(input int i);
        case (i)
            0: return CNT0;
            1: return CNT1;
            2: return CNT2;
            default: return CNT3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [1:0] s, input logic [15:0] d);
        IN_VALID = 1'b1;
        SEL      = s;
        D_IN     = d;
        tick();
    endtask

    logic [15:0] words [4];

    initial begin
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
        RST_N = 1'b0; IN_VALID = 1'b0; SEL = 2'd0; D_IN = 16'h0; OUT_READY = 4'h0; CLR_CNT = 1'b0;

        // reset state
        #3;
        chk("rst_out_valid", 32'(OUT_VALID), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_dout%0d", i), 32'(dout(i)), 32'h0);
            chk($sformatf("rst_cnt%0d", i), 32'(cnt(i)), 32'h0);
        end
        chk("rst_in_ready", 32'(IN_READY), 32'h1);

        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        OUT_READY = 4'hF;

        // one word per channel, consecutive cycles
        for (int i = 0; i < 4; i++) begin
            IN_VALID = 1'b1; SEL = 2'(i); D_IN = words[i];
            #1;
            chk($sformatf("seq_in_ready%0d", i), 32'(IN_READY), 32'h1);
            tick();
            chk($sformatf("seq_valid%0d", i), 32'(OUT_VALID[i]), 32'h1);
            chk($sformatf("seq_dout%0d", i), 32'(dout(i)), 32'(words[i]));
        end
        IN_VALID = 1'b0;
        tick();
        chk("seq_all_drained", 32'(OUT_VALID), 32'h0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("seq_cnt%0d", i), 32'(cnt(i)), 32'h1);

        // clear counters; data/valid untouched
        CLR_CNT = 1'b1;
        tick();
        CLR_CNT = 1'b0;
        chk("clr_cnt0", 32'(CNT0), 32'h0);
        chk("clr_keeps_dout3", 32'(D_OUT3), 32'h4444);

        // backpressure on channel 2
        OUT_READY = 4'b1011;
        send(2'd2, 16'hA5A5);
        chk("bp_valid2", 32'(OUT_VALID[2]), 32'h1);
        chk("bp_dout2", 32'(D_OUT2), 32'hA5A5);
        D_IN = 16'hBEEF;
        #1;
        chk("bp_in_ready_low", 32'(IN_READY), 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("bp_hold_dout2_%0d", k), 32'(D_OUT2), 32'hA5A5);
            chk($sformatf("bp_hold_valid2_%0d", k), 32'(OUT_VALID[2]), 32'h1);
        end
        OUT_READY = 4'hF;
        #1;
        chk("bp_in_ready_comb", 32'(IN_READY), 32'h1);
        tick();
        chk("bp_refill_dout2", 32'(D_OUT2), 32'hBEEF);
        chk("bp_refill_valid2", 32'(OUT_VALID[2]), 32'h1);
        chk("bp_cnt2", 32'(CNT2), 32'h1);
        IN_VALID = 1'b0;
        tick();
        chk("bp_cnt2_final", 32'(CNT2), 32'h2);

        // channel independence: channel 1 stalled full, channel 3 streams
        OUT_READY = 4'b1101;
        send(2'd1, 16'h7777);
        for (int w = 1; w <= 8; w++) begin
            IN_VALID = 1'b1; SEL = 2'd3; D_IN = 16'(w);
            #1;
            chk($sformatf("ind_in_ready%0d", w), 32'(IN_READY), 32'h1);
            tick();
            chk($sformatf("ind_dout3_%0d", w), 32'(D_OUT3), 32'(w));
        end
        IN_VALID = 1'b0;
        tick();
        chk("ind_cnt3", 32'(CNT3), 32'h8);
        chk("ind_dout1", 32'(D_OUT1), 32'h7777);
        chk("ind_valid1", 32'(OUT_VALID[1]), 32'h1);
        chk("ind_cnt1", 32'(CNT1), 32'h0);
        SEL = 2'd1;
        #1;
        chk("ind_ready_sel1_novalid", 32'(IN_READY), 32'h0);
        OUT_READY = 4'hF;
        tick();
        chk("ind_cnt1_after", 32'(CNT1), 32'h1);

        // simultaneous drain and refill on channel 0
        OUT_READY = 4'b1110;
        send(2'd0, 16'h1234);
        chk("dr_dout0_first", 32'(D_OUT0), 32'h1234);
        OUT_READY = 4'hF;
        D_IN = 16'h5678;
        #1;
        chk("dr_in_ready", 32'(IN_READY), 32'h1);
        tick();
        chk("dr_valid0", 32'(OUT_VALID[0]), 32'h1);
        chk("dr_dout0", 32'(D_OUT0), 32'h5678);
        chk("dr_cnt0", 32'(CNT0), 32'h1);
        IN_VALID = 1'b0;
        tick();
        chk("dr_cnt0_final", 32'(CNT0), 32'h2);

        // counter wrap on channel 3
        CLR_CNT = 1'b1;
        tick();
        CLR_CNT = 1'b0;
        for (int w = 0; w < 255; w++)
            send(2'd3, 16'(w));
        IN_VALID = 1'b0;
        tick();
        chk("wrap_cnt3_255", 32'(CNT3), 32'hFF);
        send(2'd3, 16'hCAFE);
        IN_VALID = 1'b0;
        tick();
        chk("wrap_cnt3_0", 32'(CNT3), 32'h0);
        chk("wrap_dout3", 32'(D_OUT3), 32'hCAFE);

        // clear beats a same-cycle delivery
        send(2'd3, 16'h0F0F);
        IN_VALID = 1'b0;
        tick();
        chk("clrp_cnt3_pre", 32'(CNT3), 32'h1);
        send(2'd3, 16'hF0F0);
        IN_VALID = 1'b0;
        CLR_CNT = 1'b1;
        tick();
        CLR_CNT = 1'b0;
        chk("clrp_cnt3", 32'(CNT3), 32'h0);
        chk("clrp_valid3", 32'(OUT_VALID[3]), 32'h0);
        chk("clrp_dout3", 32'(D_OUT3), 32'hF0F0);

        // asynchronous reset with channels 0 and 2 full
        OUT_READY = 4'b0010;
        send(2'd1, 16'h1111);
        send(2'd0, 16'hAAAA);
        send(2'd2, 16'hCCCC);
        IN_VALID = 1'b0;
        tick();
        chk("ar_valid_pre", 32'(OUT_VALID), 32'h5);
        chk("ar_cnt1_pre", 32'(CNT1), 32'h1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("ar_valid", 32'(OUT_VALID), 32'h0);
        chk("ar_dout0", 32'(D_OUT0), 32'h0);
        chk("ar_dout2", 32'(D_OUT2), 32'h0);
        chk("ar_cnt1", 32'(CNT1), 32'h0);
        #10;
        RST_N = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
